// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit 1, WIDTH data bits LSB-first, stop bit 0.
// Define PARITY_CHECK_EN to insert one even-parity bit between the data and the stop bit.
module sipo_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

`ifdef PARITY_CHECK_EN
  logic par_acc;
  logic par_bad;
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // A new error later in this block overrides the clear.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sin) begin
            state <= DATA;
            cnt   <= '0;
          end
        end

        DATA: begin
          shreg[cnt] <= sin;
`ifdef PARITY_CHECK_EN
          par_acc <= (cnt == '0) ? sin : (par_acc ^ sin);
`endif
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state <= PAR;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef PARITY_CHECK_EN
        PAR: begin
          par_bad <= par_acc ^ sin;
          state   <= STOP;
        end
`endif

        STOP: begin
          state <= IDLE;
          if (sin || par_bad) begin
            frame_err <= 1'b1;
          end else if (out_valid && !out_ready) begin
            overrun <= 1'b1;
          end else begin
            // Either the buffer is empty or its word leaves on this same edge.
            dout      <= shreg;
            out_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomized bench for sipo_frame_rx; the reference model tracks the output buffer and flags per frame.
module tb_sipo_frame_rx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] dout;
  logic         out_valid, frame_err, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_dout;
  logic         m_valid, m_ferr, m_ovr;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready), .clr_err(clr_err),
    .dout(dout), .out_valid(out_valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},      32'(dout),      32'(m_dout));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic model_reset();
    m_dout = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock: drive inputs, apply the edge to the model, check. ev: 0 none, 1 good frame ends, 2 bad frame ends.
  task automatic tick(input logic s, input logic rdy, input logic clr, input int ev,
                      input logic [W-1:0] w, input string tag);
    logic full;
    sin = s; out_ready = rdy; clr_err = clr;
    @(posedge clk);
    full = m_valid && !rdy;
    if (m_valid && rdy) m_valid = 1'b0;
    if (clr) begin m_ferr = 1'b0; m_ovr = 1'b0; end
    if (ev == 2) m_ferr = 1'b1;
    else if (ev == 1) begin
      if (full) m_ovr = 1'b1;
      else begin m_dout = w; m_valid = 1'b1; end
    end
    #1 chk_all(tag);
    @(negedge clk);
  endtask

  function automatic logic pick_rdy(input int rmode, input bit last);
    case (rmode)
      0: return 1'b0;
      1: return 1'b1;
      2: return logic'($urandom_range(0, 1));
      default: return last;  // ready only on the stop edge
    endcase
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input bit bad_stop, input bit bad_par,
                            input int rmode, input bit clr_stop, input string tag);
    int ev;
    tick(1'b1, pick_rdy(rmode, 1'b0), 1'b0, 0, d, {tag, ".start"});
    for (int i = 0; i < W; i++) tick(d[i], pick_rdy(rmode, 1'b0), 1'b0, 0, d, {tag, ".data"});
`ifdef PARITY_CHECK_EN
    tick((^d) ^ bad_par, pick_rdy(rmode, 1'b0), 1'b0, 0, d, {tag, ".par"});
    ev = (bad_stop || bad_par) ? 2 : 1;
`else
    ev = bad_stop ? 2 : 1;
`endif
    tick(bad_stop, pick_rdy(rmode, 1'b1), clr_stop, ev, d, {tag, ".stop"});
  endtask

  task automatic idle(input int n, input logic rdy, input logic clr, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, rdy, (i == 0) ? clr : 1'b0, 0, '0, tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1 chk_all("reset");
    rst = 1'b1;

    idle(20, 1'b1, 1'b0, "idle");

    send_frame(8'hA5, 0, 0, 1, 0, "a5");
    idle(2, 1'b1, 1'b0, "a5_after");

    send_frame(8'h3C, 1, 0, 1, 0, "badstop");
    idle(1, 1'b1, 1'b1, "clr");
    idle(1, 1'b1, 1'b0, "clr_after");

    send_frame(8'h11, 0, 0, 0, 0, "b2b_11");
    send_frame(8'h22, 0, 0, 0, 0, "b2b_22");
    idle(2, 1'b1, 1'b1, "drain");

    send_frame(8'h44, 0, 0, 0, 0, "hold_44");
    send_frame(8'h33, 0, 0, 3, 0, "swap_33");
    idle(2, 1'b1, 1'b0, "swap_after");

    // error and clear on the same edge: error wins
    send_frame(8'h81, 1, 0, 1, 1, "err_vs_clr");
    idle(1, 1'b1, 1'b1, "clr2");

    // park a word, then reset asynchronously in the middle of the next frame
    send_frame(8'h99, 0, 0, 0, 0, "pre_rst");
    tick(1'b1, 1'b0, 1'b0, 0, '0, "mid.start");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 0, '0, "mid.data");
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all("async_rst");
    #1 rst = 1'b1;
    idle(3, 1'b1, 1'b0, "post_rst");
    send_frame(8'h5A, 0, 0, 1, 0, "5a");
    idle(1, 1'b1, 1'b0, "5a_after");

`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 0, 0, 1, 0, "par_ok");
    idle(1, 1'b1, 1'b0, "par_ok_after");
    send_frame(8'h07, 0, 1, 1, 0, "par_bad");
    idle(1, 1'b1, 1'b1, "par_clr");
`endif

    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      send_frame(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3), ($urandom_range(0, 5) == 0), "rnd");
      idle($urandom_range(0, 2), logic'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), "rnd_gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
